// File: rtl/compound_rr_collector_if.sv
// Record-port bundle for compound_rr_collector: NUM_CH producer read ports,
// one consumer write port and the occupancy monitor.
interface compound_rr_collector_if #(
  parameter int NUM_CH  = 4,
  parameter int X_WIDTH = 32,
  parameter int DEPTH   = 4,
  parameter int SEQ_W   = 8
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [NUM_CH-1:0]         in_mode;
  logic [NUM_CH*X_WIDTH-1:0] in_x;
  logic [NUM_CH-1:0]         in_y;
  logic [NUM_CH-1:0]         in_sync;
  logic [NUM_CH-1:0]         in_notify;
  logic                      out_mode;
  logic [X_WIDTH-1:0]        out_x;
  logic                      out_y;
  logic [CH_W-1:0]           out_ch;
  logic [SEQ_W-1:0]          out_seq;
  logic                      out_sync;
  logic                      out_notify;
  logic [CNT_W-1:0]          fill_level;

  modport slave (
    input  in_mode, in_x, in_y, in_sync, out_sync,
    output in_notify, out_mode, out_x, out_y, out_ch, out_seq, out_notify, fill_level
  );

  modport master (
    output in_mode, in_x, in_y, in_sync, out_sync,
    input  in_notify, out_mode, out_x, out_y, out_ch, out_seq, out_notify, fill_level
  );
endinterface

// File: rtl/compound_rr_collector.sv
// Round-robin collector: merges NUM_CH record producers into one FIFO-buffered
// output stream tagged with source channel and a wrapping sequence number.
module compound_rr_collector #(
  parameter int NUM_CH  = 4,
  parameter int X_WIDTH = 32,
  parameter int DEPTH   = 4,
  parameter int SEQ_W   = 8
) (
  input logic clk,
  input logic rst,
  compound_rr_collector_if.slave s_bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    SECTION_IDLE = 2'd0,
    SECTION_BUSY = 2'd1,
    SECTION_FULL = 2'd2
  } section_t;

  logic [CNT_W-1:0]   r_count;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW-1:0]      r_wr_ptr;
  logic [CH_W-1:0]    r_rr_ptr;
  logic [SEQ_W-1:0]   r_seq_cnt;
  logic               r_out_notify;
  section_t           r_section;

  logic               r_mem_mode [DEPTH];
  logic [X_WIDTH-1:0] r_mem_x    [DEPTH];
  logic               r_mem_y    [DEPTH];
  logic [CH_W-1:0]    r_mem_ch   [DEPTH];

  logic               w_full;
  logic               w_grant_vld;
  logic [CH_W-1:0]    w_grant_idx;
  logic [NUM_CH-1:0]  w_notify;
  logic               w_push;
  logic               w_pop;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [CH_W-1:0]    w_rr_nxt;

  assign w_full = (r_count == CNT_W'(DEPTH));

  // Round-robin search starting at r_rr_ptr; blocked entirely while full.
  always_comb begin
    int v_idx;
    v_idx       = 0;
    w_grant_vld = 1'b0;
    w_grant_idx = {CH_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      v_idx = (int'(r_rr_ptr) + i) % NUM_CH;
      if (!w_grant_vld && !w_full && s_bus.in_sync[v_idx]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = CH_W'(v_idx);
      end else begin
        w_grant_vld = w_grant_vld;
      end
    end
  end

  // One-hot read-port notify, forced low while reset is asserted.
  always_comb begin
    w_notify = {NUM_CH{1'b0}};
    if (w_grant_vld && !rst) begin
      w_notify[w_grant_idx] = 1'b1;
    end else begin
      w_notify = {NUM_CH{1'b0}};
    end
  end

  assign w_push = w_grant_vld & ~rst;
  assign w_pop  = r_out_notify & s_bus.out_sync;

  // Next occupancy and next round-robin start point.
  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
    if (w_grant_idx == CH_W'(NUM_CH - 1)) begin
      w_rr_nxt = {CH_W{1'b0}};
    end else begin
      w_rr_nxt = w_grant_idx + 1'b1;
    end
  end

  // FIFO storage, pointers, arbitration state and sequence counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count      <= {CNT_W{1'b0}};
      r_rd_ptr     <= {AW{1'b0}};
      r_wr_ptr     <= {AW{1'b0}};
      r_rr_ptr     <= {CH_W{1'b0}};
      r_seq_cnt    <= {SEQ_W{1'b0}};
      r_out_notify <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_mode[i] <= 1'b0;
        r_mem_x[i]    <= {X_WIDTH{1'b0}};
        r_mem_y[i]    <= 1'b0;
        r_mem_ch[i]   <= {CH_W{1'b0}};
      end
    end else begin
      if (w_push) begin
        r_mem_mode[r_wr_ptr] <= s_bus.in_mode[w_grant_idx];
        r_mem_x[r_wr_ptr]    <= s_bus.in_x[w_grant_idx*X_WIDTH +: X_WIDTH];
        r_mem_y[r_wr_ptr]    <= s_bus.in_y[w_grant_idx];
        r_mem_ch[r_wr_ptr]   <= w_grant_idx;
        r_wr_ptr             <= r_wr_ptr + 1'b1;
        r_rr_ptr             <= w_rr_nxt;
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_seq_cnt <= r_seq_cnt + 1'b1;
      end
      r_count      <= w_count_nxt;
      r_out_notify <= (w_count_nxt != {CNT_W{1'b0}});
    end
  end

  // Occupancy section tracker; count moves by at most one per edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_section <= SECTION_IDLE;
    end else begin
      case (r_section)
        SECTION_IDLE: begin
          if (w_push) r_section <= SECTION_BUSY;
        end
        SECTION_BUSY: begin
          if (w_push && !w_pop && (r_count == CNT_W'(DEPTH - 1))) begin
            r_section <= SECTION_FULL;
          end else if (w_pop && !w_push && (r_count == {{(CNT_W-1){1'b0}}, 1'b1})) begin
            r_section <= SECTION_IDLE;
          end
        end
        SECTION_FULL: begin
          if (w_pop) r_section <= SECTION_BUSY;
        end
        default: r_section <= SECTION_IDLE;
      endcase
    end
  end

  assign s_bus.in_notify  = w_notify;
  assign s_bus.out_mode   = r_mem_mode[r_rd_ptr];
  assign s_bus.out_x      = r_mem_x[r_rd_ptr];
  assign s_bus.out_y      = r_mem_y[r_rd_ptr];
  assign s_bus.out_ch     = r_mem_ch[r_rd_ptr];
  assign s_bus.out_seq    = r_seq_cnt;
  assign s_bus.out_notify = r_out_notify;
  assign s_bus.fill_level = r_count;

  compound_rr_collector_chk #(
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .in_notify  (w_notify),
    .in_sync    (s_bus.in_sync),
    .count      (r_count),
    .out_notify (r_out_notify),
    .out_sync   (s_bus.out_sync),
    .section    (r_section)
  );
endmodule

// Protocol and occupancy properties for compound_rr_collector.
module compound_rr_collector_chk #(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input logic              clk,
  input logic              rst,
  input logic [NUM_CH-1:0] in_notify,
  input logic [NUM_CH-1:0] in_sync,
  input logic [CNT_W-1:0]  count,
  input logic              out_notify,
  input logic              out_sync,
  input logic [1:0]        section
);
  a_notify_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(in_notify));
  a_count_bound:    assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH));
  a_no_pop_empty:   assert property (@(posedge clk) disable iff (rst)
                      !(out_notify && out_sync && (count == {CNT_W{1'b0}})));
  a_no_push_full:   assert property (@(posedge clk) disable iff (rst)
                      !((|(in_notify & in_sync)) && (count == CNT_W'(DEPTH))));
  a_section_idle:   assert property (@(posedge clk) disable iff (rst)
                      (section == 2'd0) == (count == {CNT_W{1'b0}}));
  a_section_full:   assert property (@(posedge clk) disable iff (rst)
                      (section == 2'd2) == (count == CNT_W'(DEPTH)));
endmodule

// File: tb/tb_compound_rr_collector.sv
// Directed bench for compound_rr_collector: arbitration order, FIFO fill/drain,
// full-with-pop, asynchronous reset and sequence-number wrap.
module tb_compound_rr_collector;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  compound_rr_collector_if #(.NUM_CH(4), .X_WIDTH(32), .DEPTH(4), .SEQ_W(8)) bus ();
  compound_rr_collector_if #(.NUM_CH(4), .X_WIDTH(32), .DEPTH(4), .SEQ_W(2)) bus2 ();

  compound_rr_collector #(.NUM_CH(4), .X_WIDTH(32), .DEPTH(4), .SEQ_W(8)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .s_bus (bus.slave)
  );

  compound_rr_collector #(.NUM_CH(4), .X_WIDTH(32), .DEPTH(4), .SEQ_W(2)) u_dut_seq2 (
    .clk   (clk),
    .rst   (rst),
    .s_bus (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    logic [3:0] v_exp;
    logic [3:0] v_mode;
    logic [3:0] v_y;
    int         v_ch;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.in_mode = 4'b0000;  bus.in_x = 128'd0;  bus.in_y = 4'b0000;
    bus.in_sync = 4'b1111;  bus.out_sync = 1'b0;
    bus2.in_mode = 4'b0000; bus2.in_x = 128'd0; bus2.in_y = 4'b0000;
    bus2.in_sync = 4'b0000; bus2.out_sync = 1'b0;

    // Reset state, with every channel requesting
    @(negedge clk);
    chk("rst_in_notify", 64'(bus.in_notify), 64'h0);
    chk("rst_out_notify", 64'(bus.out_notify), 64'h0);
    chk("rst_fill", 64'(bus.fill_level), 64'h0);
    chk("rst_out_x", 64'(bus.out_x), 64'h0);
    chk("rst_out_ch", 64'(bus.out_ch), 64'h0);
    chk("rst_out_seq", 64'(bus.out_seq), 64'h0);
    chk("rst_out_mode_y", 64'({bus.out_mode, bus.out_y}), 64'h0);
    next_cycle();
    rst = 1'b0;
    bus.in_sync = 4'b0000;

    // Single record from ch2
    bus.in_mode = 4'b0100; bus.in_y = 4'b0100; bus.in_x[2*32 +: 32] = 32'h1234;
    bus.in_sync = 4'b0100; bus.out_sync = 1'b1;
    @(negedge clk);
    chk("t1_in_notify", 64'(bus.in_notify), 64'h4);
    chk("t1_out_notify0", 64'(bus.out_notify), 64'h0);
    next_cycle();
    bus.in_sync = 4'b0000;
    @(negedge clk);
    chk("t1_in_notify_off", 64'(bus.in_notify), 64'h0);
    chk("t1_out_notify", 64'(bus.out_notify), 64'h1);
    chk("t1_out_x", 64'(bus.out_x), 64'h1234);
    chk("t1_out_ch", 64'(bus.out_ch), 64'h2);
    chk("t1_out_seq", 64'(bus.out_seq), 64'h0);
    chk("t1_out_mode_y", 64'({bus.out_mode, bus.out_y}), 64'h3);
    chk("t1_fill1", 64'(bus.fill_level), 64'h1);
    next_cycle();
    @(negedge clk);
    chk("t1_fill0", 64'(bus.fill_level), 64'h0);
    chk("t1_out_notify_end", 64'(bus.out_notify), 64'h0);
    next_cycle();

    // Round-robin streaming with all channels requesting
    do_reset();
    v_mode = 4'b1010; v_y = 4'b0110;
    bus.in_mode = v_mode; bus.in_y = v_y;
    for (int c = 0; c < 4; c++) bus.in_x[c*32 +: 32] = 32'h100 + 32'(c);
    bus.in_sync = 4'b1111; bus.out_sync = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      v_exp = 4'b0001 << (k % 4);
      chk("t2_grant", 64'(bus.in_notify), 64'(v_exp));
      if (k > 0) begin
        v_ch = (k - 1) % 4;
        chk("t2_out_notify", 64'(bus.out_notify), 64'h1);
        chk("t2_out_ch", 64'(bus.out_ch), 64'(v_ch));
        chk("t2_out_seq", 64'(bus.out_seq), 64'(k - 1));
        chk("t2_out_x", 64'(bus.out_x), 64'h100 + 64'(v_ch));
        chk("t2_out_mode_y", 64'({bus.out_mode, bus.out_y}), 64'({v_mode[v_ch], v_y[v_ch]}));
        chk("t2_fill", 64'(bus.fill_level), 64'h1);
      end else begin
        chk("t2_fill_first", 64'(bus.fill_level), 64'h0);
      end
      next_cycle();
    end
    bus.in_sync = 4'b0000;
    @(negedge clk);
    chk("t2_last_ch", 64'(bus.out_ch), 64'h3);
    chk("t2_last_seq", 64'(bus.out_seq), 64'h7);
    next_cycle();
    @(negedge clk);
    chk("t2_drained", 64'(bus.fill_level), 64'h0);
    next_cycle();

    // Fill to full with the consumer stalled
    bus.out_sync = 1'b0; bus.in_sync = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      v_exp = 4'b0001 << k;
      chk("t3_grant", 64'(bus.in_notify), 64'(v_exp));
      chk("t3_fill", 64'(bus.fill_level), 64'(k));
      next_cycle();
    end
    @(negedge clk);
    chk("t3_full_notify", 64'(bus.in_notify), 64'h0);
    chk("t3_full_fill", 64'(bus.fill_level), 64'h4);
    chk("t3_full_out_notify", 64'(bus.out_notify), 64'h1);
    chk("t3_head_ch", 64'(bus.out_ch), 64'h0);
    chk("t3_head_seq", 64'(bus.out_seq), 64'h8);
    next_cycle();

    // Full with pop and push requested together: only the pop happens
    bus.out_sync = 1'b1;
    @(negedge clk);
    chk("t4_full_blocked", 64'(bus.in_notify), 64'h0);
    chk("t4_full_fill", 64'(bus.fill_level), 64'h4);
    next_cycle();
    bus.out_sync = 1'b0;
    @(negedge clk);
    chk("t4_after_pop_fill", 64'(bus.fill_level), 64'h3);
    chk("t4_resume_grant", 64'(bus.in_notify), 64'h1);
    chk("t4_head_ch", 64'(bus.out_ch), 64'h1);
    chk("t4_head_seq", 64'(bus.out_seq), 64'h9);
    next_cycle();
    bus.in_sync = 4'b0000; bus.out_sync = 1'b1;
    for (int j = 0; j < 4; j++) begin
      v_ch = (j + 1) % 4;
      @(negedge clk);
      chk("t4_drain_fill", 64'(bus.fill_level), 64'(4 - j));
      chk("t4_drain_notify", 64'(bus.out_notify), 64'h1);
      chk("t4_drain_ch", 64'(bus.out_ch), 64'(v_ch));
      chk("t4_drain_seq", 64'(bus.out_seq), 64'(9 + j));
      chk("t4_drain_x", 64'(bus.out_x), 64'h100 + 64'(v_ch));
      next_cycle();
    end
    @(negedge clk);
    chk("t4_empty_fill", 64'(bus.fill_level), 64'h0);
    chk("t4_empty_notify", 64'(bus.out_notify), 64'h0);
    next_cycle();

    // Asynchronous reset with three records buffered
    bus.out_sync = 1'b0; bus.in_sync = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      v_exp = (k == 0) ? 4'b0010 : ((k == 1) ? 4'b0100 : 4'b0001);
      chk("t5_grant", 64'(bus.in_notify), 64'(v_exp));
      next_cycle();
    end
    @(negedge clk);
    chk("t5_fill3", 64'(bus.fill_level), 64'h3);
    chk("t5_pending_grant", 64'(bus.in_notify), 64'h2);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_out_notify", 64'(bus.out_notify), 64'h0);
    chk("t5_rst_in_notify", 64'(bus.in_notify), 64'h0);
    chk("t5_rst_fill", 64'(bus.fill_level), 64'h0);
    bus.in_sync = 4'b1111; bus.out_sync = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rr_restart", 64'(bus.in_notify), 64'h1);
    chk("t5_post_fill", 64'(bus.fill_level), 64'h0);
    next_cycle();
    bus.in_sync = 4'b0000;
    @(negedge clk);
    chk("t5_first_notify", 64'(bus.out_notify), 64'h1);
    chk("t5_first_ch", 64'(bus.out_ch), 64'h0);
    chk("t5_first_seq", 64'(bus.out_seq), 64'h0);
    chk("t5_first_x", 64'(bus.out_x), 64'h100);
    next_cycle();

    // Two-bit sequence counter wrap over five consecutive pops
    bus2.in_x[31:0] = 32'h00ab; bus2.in_sync = 4'b0001; bus2.out_sync = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("t6_out_notify0", 64'(bus2.out_notify), 64'h0);
      end else begin
        chk("t6_out_notify", 64'(bus2.out_notify), 64'h1);
        chk("t6_out_seq", 64'(bus2.out_seq), 64'((k - 1) % 4));
      end
      next_cycle();
    end
    bus2.in_sync = 4'b0000;
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
